// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 4-bit ripple-carry adder.
// A request is granted in IDLE, the winner's operands are latched, and the
// registered result comes out one edge later with VALID and RID.
// Optional feature macro: ADDER_ARBITER_ROUND_ROBIN_EN. When it is defined, a
// tie between the requesters goes to the one not granted last. When it is
// undefined, requester 0 always wins a tie.
module adder_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  input  logic       REQ1,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic       GNT0,
  output logic       GNT1,
  output logic [3:0] SUM,
  output logic       COUT,
  output logic       VALID,
  output logic       RID,
  output logic       BUSY
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic       gnt0_reg, gnt0_next;
  logic       gnt1_reg, gnt1_next;
  logic       valid_reg, valid_next;
  logic       busy_reg, busy_next;
  logic [3:0] sum_reg, sum_next;
  logic       cout_reg, cout_next;
  logic       rid_reg, rid_next;
  logic [3:0] op_a_reg, op_a_next;
  logic [3:0] op_b_reg, op_b_next;
  logic       pick;
  logic [3:0] adder_sum;
  logic [4:0] carry;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
  logic       last_reg, last_next;
`endif

  // The single shared adder: a chain of full-adder cells on the latched operands.
  assign carry[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign adder_sum[gi] = op_a_reg[gi] ^ op_b_reg[gi] ^ carry[gi];
      assign carry[gi+1]   = (op_a_reg[gi] & op_b_reg[gi]) |
                             (carry[gi] & (op_a_reg[gi] ^ op_b_reg[gi]));
    end
  endgenerate

  // Winner selection. It is only meaningful when at least one REQ is high.
  // A single request always wins.
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
  assign pick = (REQ0 && REQ1) ? ~last_reg : REQ1;
`else
  assign pick = ~REQ0;
`endif

  // Next-state and next-output logic. Pulse outputs default low and results hold.
  always_comb begin
    state_next = state_reg;
    gnt0_next  = 1'b0;
    gnt1_next  = 1'b0;
    valid_next = 1'b0;
    busy_next  = 1'b0;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    rid_next   = rid_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
    last_next  = last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (REQ0 || REQ1) begin
          op_a_next  = pick ? A1 : A0;
          op_b_next  = pick ? B1 : B0;
          gnt0_next  = ~pick;
          gnt1_next  = pick;
          busy_next  = 1'b1;
          state_next = CALC;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
          last_next  = pick;
`endif
        end
      end
      CALC: begin
        // Inputs are ignored here. GNT1 is high for the whole CALC cycle
        // exactly when requester 1 won, so it doubles as the owner index.
        sum_next   = adder_sum;
        cout_next  = carry[4];
        rid_next   = gnt1_reg;
        valid_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      sum_reg   <= 4'd0;
      cout_reg  <= 1'b0;
      rid_reg   <= 1'b0;
      op_a_reg  <= 4'd0;
      op_b_reg  <= 4'd0;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      last_reg  <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      gnt0_reg  <= gnt0_next;
      gnt1_reg  <= gnt1_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      rid_reg   <= rid_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      last_reg  <= last_next;
`endif
    end
  end

  assign GNT0  = gnt0_reg;
  assign GNT1  = gnt1_reg;
  assign VALID = valid_reg;
  assign BUSY  = busy_reg;
  assign SUM   = sum_reg;
  assign COUT  = cout_reg;
  assign RID   = rid_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a transaction-level reference model
// is compared on every negedge, plus directed operations with literal results.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, cout, valid, rid, busy;
  logic [3:0] sum;

  int n_tests = 0;
  int n_fail  = 0;

  adder_arbiter dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .A0(a0), .B0(b0),
    .REQ1(req1), .A1(a1), .B1(b1),
    .GNT0(gnt0), .GNT1(gnt1), .SUM(sum), .COUT(cout),
    .VALID(valid), .RID(rid), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One pending operation at most. A tie goes to requester 0 (fixed priority)
  // or to whoever was not granted last (round robin).
  logic       exp_gnt0, exp_gnt1, exp_valid, exp_busy, exp_cout, exp_rid;
  logic [3:0] exp_sum;
  bit         m_pending = 0;
  bit         m_who = 0;
  bit         model_ready = 0;
  int         m_a = 0, m_b = 0;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
  bit         m_last = 1;
`endif

  function automatic bit choose(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      return !m_last;
`else
      return 1'b0;
`endif
    end
    return r1 ? 1'b1 : 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_gnt0 <= 0; exp_gnt1 <= 0; exp_valid <= 0; exp_busy <= 0;
      exp_sum <= 0; exp_cout <= 0; exp_rid <= 0;
      m_pending <= 0; m_a <= 0; m_b <= 0; model_ready <= 1;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      m_last <= 1;
`endif
    end else if (m_pending) begin
      exp_sum   <= 4'((m_a + m_b) % 16);
      exp_cout  <= ((m_a + m_b) > 15);
      exp_rid   <= m_who;
      exp_valid <= 1; exp_gnt0 <= 0; exp_gnt1 <= 0; exp_busy <= 0;
      m_pending <= 0;
    end else begin
      exp_valid <= 0;
      if (req0 || req1) begin
        m_who     <= choose(req0, req1);
        m_a       <= int'(choose(req0, req1) ? a1 : a0);
        m_b       <= int'(choose(req0, req1) ? b1 : b0);
        exp_gnt0  <= !choose(req0, req1);
        exp_gnt1  <= choose(req0, req1);
        exp_busy  <= 1;
        m_pending <= 1;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
        m_last    <= choose(req0, req1);
`endif
      end else begin
        exp_gnt0 <= 0; exp_gnt1 <= 0; exp_busy <= 0;
      end
    end
  end

  // Cycle compare against the model. It also prints one line per result.
  always @(negedge clk) begin
    if (model_ready) begin
      check("cyc_gnt0",  8'(gnt0),  8'(exp_gnt0));
      check("cyc_gnt1",  8'(gnt1),  8'(exp_gnt1));
      check("cyc_valid", 8'(valid), 8'(exp_valid));
      check("cyc_busy",  8'(busy),  8'(exp_busy));
      check("cyc_sum",   8'(sum),   8'(exp_sum));
      check("cyc_cout",  8'(cout),  8'(exp_cout));
      check("cyc_rid",   8'(rid),   8'(exp_rid));
      if (valid === 1'b1)
        $display("[TB] result rid=%0d cout=%0d sum=%0d", rid, cout, sum);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input bit who, input logic [3:0] a, input logic [3:0] b,
                        input bit poke, input logic [3:0] poke_a,
                        output logic [3:0] s, output logic c, output logic r);
    bit seen;
    s = 0; c = 0; r = 0;
    @(negedge clk);
    if (who) begin req1 = 1; a1 = a; b1 = b; end
    else     begin req0 = 1; a0 = a; b0 = b; end
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = who ? (gnt1 === 1'b1) : (gnt0 === 1'b1);
    end
    check("grant_seen", 8'(seen), 8'd1);
    req0 = 0; req1 = 0;
    if (poke) begin
      if (who) a1 = poke_a; else a0 = poke_a;
    end
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin seen = 1; s = sum; c = cout; r = rid; end
    end
    check("valid_seen", 8'(seen), 8'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] s;
    logic       c, r;
    logic       gq [4];
    logic [3:0] sq [4];
    bit         eg [4];
    int         es [4];
    int         ng, nv;

    rst = 1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    check("rst_gnt0", 8'(gnt0), 8'd0);
    check("rst_gnt1", 8'(gnt1), 8'd0);
    check("rst_valid", 8'(valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_sum", 8'(sum), 8'd0);
    check("rst_cout", 8'(cout), 8'd0);
    check("rst_rid", 8'(rid), 8'd0);
    rst = 0;

    // Requester 0: 3+4
    run_op(0, 4'd3, 4'd4, 0, 4'd0, s, c, r);
    check("op0_sum", 8'(s), 8'd7);
    check("op0_cout", 8'(c), 8'd0);
    check("op0_rid", 8'(r), 8'd0);

    // Requester 1: 9+8 overflows
    run_op(1, 4'd9, 4'd8, 0, 4'd0, s, c, r);
    check("op1_sum", 8'(s), 8'd1);
    check("op1_cout", 8'(c), 8'd1);
    check("op1_rid", 8'(r), 8'd1);

    // Both held high: arbitration order and results
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
    eg = '{0, 1, 0, 1}; es = '{2, 4, 2, 4};
`else
    eg = '{0, 0, 0, 0}; es = '{2, 2, 2, 2};
`endif
    @(negedge clk);
    req0 = 1; req1 = 1; a0 = 1; b0 = 1; a1 = 2; b1 = 2;
    ng = 0; nv = 0;
    for (int k = 0; k < 20 && (ng < 4 || nv < 4); k++) begin
      @(negedge clk);
      if ((gnt0 === 1'b1 || gnt1 === 1'b1) && ng < 4) begin gq[ng] = gnt1; ng++; end
      if (valid === 1'b1 && nv < 4) begin sq[nv] = sum; nv++; end
      if (ng == 4) begin req0 = 0; req1 = 0; end
    end
    req0 = 0; req1 = 0;
    check("both_grants", 8'(ng), 8'd4);
    check("both_valids", 8'(nv), 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check("both_grant_id", 8'(gq[i]), 8'(eg[i]));
      if (i < nv) check("both_sum", 8'(sq[i]), 8'(es[i]));
    end
    repeat (3) @(negedge clk);

    // Operand change after grant must not leak into the result
    run_op(0, 4'd5, 4'd5, 1, 4'd15, s, c, r);
    check("hold_sum", 8'(s), 8'd10);
    check("hold_cout", 8'(c), 8'd0);

    // Reset while in CALC drops the operation and restarts arbitration
    @(negedge clk);
    req0 = 1; a0 = 1; b0 = 1;
    @(negedge clk);
    check("rstcalc_gnt", 8'(gnt0), 8'd1);
    req0 = 0; rst = 1;
    @(negedge clk);
    check("rstcalc_valid", 8'(valid), 8'd0);
    check("rstcalc_busy", 8'(busy), 8'd0);
    rst = 0;
    req0 = 1; req1 = 1; a0 = 2; b0 = 3; a1 = 4; b1 = 4;
    @(negedge clk);
    check("after_rst_gnt0", 8'(gnt0), 8'd1);
    check("after_rst_gnt1", 8'(gnt1), 8'd0);
    req0 = 0; req1 = 0;
    @(negedge clk);
    check("after_rst_valid", 8'(valid), 8'd1);
    check("after_rst_sum", 8'(sum), 8'd5);
    check("after_rst_rid", 8'(rid), 8'd0);

    // Every operand pair through requester 0
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_op(0, 4'(ai), 4'(bi), 0, 4'd0, s, c, r);
        check("all_pairs", 8'({c, s}), 8'(ai + bi));
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
